// File: rtl/jtframe_joy2osd_pkg.sv
// rtl/jtframe_joy2osd_pkg.sv - key codes, command codes, FSM states and key priority for the joystick OSD encoder
package jtframe_joy2osd_pkg;

  localparam logic [4:0] KEY_RIGHT  = 5'd23;
  localparam logic [4:0] KEY_LEFT   = 5'd27;
  localparam logic [4:0] KEY_DOWN   = 5'd29;
  localparam logic [4:0] KEY_UP     = 5'd30;
  localparam logic [4:0] KEY_RETURN = 5'd15;
  localparam logic [4:0] KEY_NONE   = 5'd31;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_OSD = 3'b011;

  localparam logic [7:0] IDLE_BYTE = 8'h3f;
  localparam logic [7:0] OFF_BYTE  = 8'hff;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // nav = {A, U, D, L, R}; right wins over everything, enter has the lowest priority
  function automatic logic [4:0] key_code(input logic [4:0] nav);
    logic [4:0] code;
    if (nav[0])      code = KEY_RIGHT;
    else if (nav[1]) code = KEY_LEFT;
    else if (nav[2]) code = KEY_DOWN;
    else if (nav[3]) code = KEY_UP;
    else if (nav[4]) code = KEY_RETURN;
    else             code = KEY_NONE;
    return code;
  endfunction

endpackage

// File: rtl/jtframe_joy2osd_rpt.sv
// rtl/jtframe_joy2osd_rpt.sv - per-key press/auto-repeat timer, shows a key code for one cen period per event
module jtframe_joy2osd_rpt
  import jtframe_joy2osd_pkg::*;
#(
  parameter int RPT_DLY = 24,
  parameter int RPT_PER = 6
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic [4:0] key_in,
  output logic [4:0] key_out
);

  localparam int RMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RW   = $clog2(RMAX + 1);

  logic [4:0]    last_key;
  logic [RW-1:0] rpt_cnt;
  logic          show;

  // Track the key seen at each cen; a new key shows at once, a held key shows at RPT_DLY then every RPT_PER
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_key <= KEY_NONE;
      rpt_cnt  <= '0;
      show     <= 1'b0;
    end else if (cen) begin
      if (key_in != last_key) begin
        last_key <= key_in;
        rpt_cnt  <= RW'(RPT_DLY);
        show     <= (key_in != KEY_NONE);
      end else if (key_in == KEY_NONE) begin
        rpt_cnt  <= '0;
        show     <= 1'b0;
      end else if (rpt_cnt <= RW'(1)) begin
        rpt_cnt  <= RW'(RPT_PER);
        show     <= 1'b1;
      end else begin
        rpt_cnt  <= rpt_cnt - 1'b1;
        show     <= 1'b0;
      end
    end
  end

  assign key_out = show ? last_key : KEY_NONE;

endmodule

// File: rtl/jtframe_joy2osd.sv
// rtl/jtframe_joy2osd.sv - joystick to OSD command byte encoder; JTFRAME_OSD_AUTOREPEAT_EN adds key auto-repeat
module jtframe_joy2osd
  import jtframe_joy2osd_pkg::*;
#(
  parameter int              NJOY    = 2,
  parameter int              JW      = 12,
  parameter logic [JW-1:0]   COMBO   = 12'h440,
  parameter int              HOLD    = 4,
  parameter int              STRETCH = 16,
  parameter int              HOLDOFF = 65535,
  parameter int              RPT_DLY = 24,
  parameter int              RPT_PER = 6
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic                 dwn,
  input  logic [NJOY*JW-1:0]   joys,
  output logic [7:0]           nept_din,
  output logic                 osd_fire
);

  localparam int HW = $clog2(HOLDOFF + 1);
  localparam int CW = $clog2(HOLD + 1);
  localparam int SW = $clog2(STRETCH + 1);

  state_t        state, state_next;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] combo_cnt;
  logic [SW-1:0] stretch_cnt;
  logic [JW-1:0] mix;
  logic          combo_all;
  logic          fire_now;
  logic [4:0]    key_live;
  logic [4:0]    key_field;
  logic [2:0]    cmd;
  logic [7:0]    out_next;

  // Merge every joystick channel into one button word
  always_comb begin
    mix = '0;
    for (int i = 0; i < NJOY; i++) mix = mix | joys[i*JW +: JW];
  end

  assign combo_all = ((mix & COMBO) == COMBO);
  assign fire_now  = (state == ST_RUN) && combo_all && cen && (combo_cnt == CW'(HOLD - 1));

`ifdef JTFRAME_OSD_AUTOREPEAT_EN
  jtframe_joy2osd_rpt #(
    .RPT_DLY (RPT_DLY),
    .RPT_PER (RPT_PER)
  ) u_rpt (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .key_in  (key_code(mix[4:0])),
    .key_out (key_live)
  );
`else
  assign key_live = key_code(mix[4:0]);

  // Repeat timing is only consumed by the auto-repeat build
  if (RPT_DLY < 1 || RPT_PER < 1) begin : g_rpt_timing_unused
  end
`endif

  assign cmd       = (stretch_cnt != '0) ? CMD_OSD : CMD_NOP;
  assign key_field = (combo_all || stretch_cnt != '0) ? KEY_NONE : key_live;

  // Start-up sequencing: holdoff countdown, then wait for the first download, then run for good
  always_comb begin
    state_next = state;
    out_next   = OFF_BYTE;
    case (state)
      ST_HOLD: begin
        out_next = OFF_BYTE;
        if (hold_cnt <= HW'(1)) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        out_next = IDLE_BYTE;
        if (dwn) state_next = ST_RUN;
      end
      default: begin
        out_next   = {cmd, key_field};
        state_next = ST_RUN;
      end
    endcase
  end

  // State register and holdoff counter, which stops at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_HOLD;
      hold_cnt <= HW'(HOLDOFF);
    end else begin
      state <= state_next;
      if (state == ST_HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // Combo hold counter, OSD stretch timer and the single fire pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      combo_cnt   <= '0;
      stretch_cnt <= '0;
      osd_fire    <= 1'b0;
    end else begin
      osd_fire <= 1'b0;
      if (state != ST_RUN || !combo_all) combo_cnt <= '0;
      else if (cen && combo_cnt != CW'(HOLD)) combo_cnt <= combo_cnt + 1'b1;
      if (cen && stretch_cnt != '0) stretch_cnt <= stretch_cnt - 1'b1;
      if (fire_now) begin
        stretch_cnt <= SW'(STRETCH);
        osd_fire    <= 1'b1;
      end
    end
  end

  // Registered output byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nept_din <= OFF_BYTE;
    else        nept_din <= out_next;
  end

endmodule

// File: tb/tb_jtframe_joy2osd.sv
// tb/tb_jtframe_joy2osd.sv - directed bench for jtframe_joy2osd
module tb_jtframe_joy2osd;

  localparam int NJOY = 2;
  localparam int JW   = 12;

  logic                 clk;
  logic                 rst_n;
  logic                 cen;
  logic                 dwn;
  logic [NJOY*JW-1:0]   joys;
  logic [7:0]           nept_din;
  logic                 osd_fire;

  int checks;
  int errors;
  int fire_cnt;

  jtframe_joy2osd #(
    .NJOY    (NJOY),
    .JW      (JW),
    .COMBO   (12'h440),
    .HOLD    (4),
    .STRETCH (16),
    .HOLDOFF (8),
    .RPT_DLY (24),
    .RPT_PER (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .dwn      (dwn),
    .joys     (joys),
    .nept_din (nept_din),
    .osd_fire (osd_fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && osd_fire) fire_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cen_tick();
    cen = 1'b1;
    tick();
    cen = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cen = 1'b0; dwn = 1'b0; joys = '0;
    tick();
    tick();
    checks++;
    if (nept_din !== 8'hff) begin
      errors++; $display("FAIL reset_din: got %h want ff", nept_din);
    end
    checks++;
    if (osd_fire !== 1'b0) begin
      errors++; $display("FAIL reset_fire: got %b want 0", osd_fire);
    end
  endtask

  task automatic test_holdoff();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (nept_din !== 8'hff) begin
        errors++; $display("FAIL holdoff_ff clk %0d: got %h want ff", i, nept_din);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (nept_din !== 8'h3f) begin
        errors++; $display("FAIL wait_3f clk %0d: got %h want 3f", i, nept_din);
      end
    end
    dwn = 1'b1;
    tick();
    tick();
    checks++;
    if (nept_din !== 8'hff) begin
      errors++; $display("FAIL run_idle: got %h want ff", nept_din);
    end
  endtask

`ifndef JTFRAME_OSD_AUTOREPEAT_EN
  task automatic test_keys();
    logic [23:0] vec_j [9];
    logic [7:0]  vec_d [9];
    vec_j[0] = 24'h004001; vec_d[0] = 8'hf7;
    vec_j[1] = 24'h002000; vec_d[1] = 8'hfb;
    vec_j[2] = 24'h008004; vec_d[2] = 8'hfd;
    vec_j[3] = 24'h008000; vec_d[3] = 8'hfe;
    vec_j[4] = 24'h000010; vec_d[4] = 8'hef;
    vec_j[5] = 24'h000018; vec_d[5] = 8'hfe;
    vec_j[6] = 24'h01f000; vec_d[6] = 8'hf7;
    vec_j[7] = 24'h000020; vec_d[7] = 8'hff;
    vec_j[8] = 24'h000000; vec_d[8] = 8'hff;
    for (int i = 0; i < 9; i++) begin
      joys = vec_j[i];
      tick();
      checks++;
      if (nept_din !== vec_d[i]) begin
        errors++; $display("FAIL key vec %0d joys %h: got %h want %h", i, vec_j[i], nept_din, vec_d[i]);
      end
    end
  endtask
`endif

  task automatic test_osd_combo();
    int f0;
    f0 = fire_cnt;
    joys = 24'h400041;
    for (int i = 0; i < 3; i++) cen_tick();
    checks++;
    if (fire_cnt !== f0) begin
      errors++; $display("FAIL combo_early_fire: got %0d want %0d", fire_cnt, f0);
    end
    checks++;
    if (nept_din !== 8'hff) begin
      errors++; $display("FAIL combo_key_forced: got %h want ff", nept_din);
    end
    cen_tick();
    checks++;
    if (fire_cnt !== f0 + 1) begin
      errors++; $display("FAIL combo_fire: got %0d want %0d", fire_cnt, f0 + 1);
    end
    checks++;
    if (nept_din !== 8'h7f) begin
      errors++; $display("FAIL osd_first: got %h want 7f", nept_din);
    end
    for (int i = 1; i <= 15; i++) begin
      cen_tick();
      checks++;
      if (nept_din !== 8'h7f) begin
        errors++; $display("FAIL osd_stretch cen %0d: got %h want 7f", i, nept_din);
      end
    end
    cen_tick();
    checks++;
    if (nept_din !== 8'hff) begin
      errors++; $display("FAIL osd_end: got %h want ff", nept_din);
    end
    for (int i = 0; i < 8; i++) cen_tick();
    checks++;
    if (fire_cnt !== f0 + 1) begin
      errors++; $display("FAIL no_refire: got %0d want %0d", fire_cnt, f0 + 1);
    end
    checks++;
    if (nept_din !== 8'hff) begin
      errors++; $display("FAIL held_after_stretch: got %h want ff", nept_din);
    end
    joys = 24'h0;
    cen_tick();
  endtask

  task automatic test_combo_short();
    int f0;
    f0 = fire_cnt;
    for (int r = 0; r < 2; r++) begin
      joys = 24'h400040;
      for (int i = 0; i < 3; i++) cen_tick();
      joys = 24'h0;
      tick();
      tick();
      checks++;
      if (nept_din !== 8'hff) begin
        errors++; $display("FAIL short_cmd round %0d: got %h want ff", r, nept_din);
      end
    end
    cen_tick();
    checks++;
    if (fire_cnt !== f0) begin
      errors++; $display("FAIL short_fire: got %0d want %0d", fire_cnt, f0);
    end
  endtask

`ifdef JTFRAME_OSD_AUTOREPEAT_EN
  task automatic test_autorepeat();
    logic [7:0] want;
    joys = 24'h0;
    cen_tick();
    joys = 24'h008000;
    for (int i = 0; i < 40; i++) begin
      cen_tick();
      want = (i == 0 || i == 24 || i == 30 || i == 36) ? 8'hfe : 8'hff;
      checks++;
      if (nept_din !== want) begin
        errors++; $display("FAIL autorepeat cen %0d: got %h want %h", i, nept_din, want);
      end
    end
    joys = 24'h0;
    cen_tick();
  endtask
`endif

  task automatic test_reset_midrun();
    joys = 24'h000001;
    tick();
    tick();
`ifndef JTFRAME_OSD_AUTOREPEAT_EN
    checks++;
    if (nept_din !== 8'hf7) begin
      errors++; $display("FAIL midrun_key: got %h want f7", nept_din);
    end
`endif
    rst_n = 1'b0;
    #1;
    checks++;
    if (nept_din !== 8'hff) begin
      errors++; $display("FAIL midrun_async: got %h want ff", nept_din);
    end
    tick();
    checks++;
    if (nept_din !== 8'hff || osd_fire !== 1'b0) begin
      errors++; $display("FAIL midrun_held: got %h/%b want ff/0", nept_din, osd_fire);
    end
    dwn = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (nept_din !== 8'hff) begin
        errors++; $display("FAIL rehold_ff clk %0d: got %h want ff", i, nept_din);
      end
    end
    tick();
    checks++;
    if (nept_din !== 8'h3f) begin
      errors++; $display("FAIL rehold_wait: got %h want 3f", nept_din);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    fire_cnt = 0;
    test_reset();
    test_holdoff();
`ifndef JTFRAME_OSD_AUTOREPEAT_EN
    test_keys();
`endif
    test_osd_combo();
    test_combo_short();
`ifdef JTFRAME_OSD_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
